fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM feeding a {pc, instruction} prefetch FIFO to decode.
// Define FETCH_BUF2_EN for a 2-entry buffer; otherwise the buffer holds a single entry.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
`ifdef FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0] FULL = 2'(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n, drain_pc, drain_pc_n, target;
    logic [31:0] buf_pc [DEPTH];
    logic [31:0] buf_ins [DEPTH];
    logic rd_ptr, wr_ptr, push, pop;
    logic [1:0] count, count_pp;
    assign target = {redirect_pc[31:2], 2'b00};
    assign imem_address = fetch_pc;
    assign imem_read = state != IDLE;
    assign instr_valid = count != 2'd0 && !redirect;
    assign instruction = buf_ins[rd_ptr];
    assign instr_pc = buf_pc[rd_ptr];
    assign pop = instr_valid && instr_ready;
    assign push = state == REQ && imem_resp && !redirect;
    assign count_pp = count + {1'b0, push} - {1'b0, pop};
    // DRAIN keeps the stale address on the bus; the redirect target waits in drain_pc
    always_comb begin
        state_n = state;
        fetch_pc_n = fetch_pc;
        drain_pc_n = drain_pc;
        case (state)
            IDLE: begin
                state_n = (redirect || count_pp < FULL) ? REQ : IDLE;
                fetch_pc_n = redirect ? target : fetch_pc;
            end
            REQ: begin
                state_n = imem_resp ? ((!redirect && count_pp == FULL) ? IDLE : REQ)
                                    : (redirect ? DRAIN : REQ);
                fetch_pc_n = imem_resp ? (redirect ? target : fetch_pc + 32'd4) : fetch_pc;
                drain_pc_n = redirect ? target : drain_pc;
            end
            DRAIN: begin
                state_n = imem_resp ? REQ : DRAIN;
                drain_pc_n = redirect ? target : drain_pc;
                fetch_pc_n = imem_resp ? drain_pc_n : fetch_pc;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            fetch_pc <= RESET_PC;
            drain_pc <= RESET_PC;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i] <= 32'd0;
                buf_ins[i] <= 32'd0;
            end
        end else begin
            state <= state_n;
            fetch_pc <= fetch_pc_n;
            drain_pc <= drain_pc_n;
            if (redirect) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count <= 2'd0;
            end else begin
                count <= count_pp;
                if (push) begin
                    buf_pc[wr_ptr] <= fetch_pc;
                    buf_ins[wr_ptr] <= imem_rdata;
                    wr_ptr <= (DEPTH == 1) ? 1'b0 : ~wr_ptr;
                end
                if (pop) rd_ptr <= (DEPTH == 1) ? 1'b0 : ~rd_ptr;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench; the reference model is the expected in-order PC stream
// (restarted at every redirect/reset) with instruction data given by a fixed address hash.
module tb_fetch_unit;
`ifdef FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    logic clk = 0, rst = 1;
    logic [31:0] imem_address, imem_rdata = 0, instruction, instr_pc, redirect_pc = 0;
    logic imem_read, imem_resp = 0, instr_valid, instr_ready = 0, redirect = 0;
    int vectors = 0, miscompares = 0, accepts = 0, max_lat = 0, lat = 0, a0;
    bit mem_en = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_log[$];
    always #5 clk = ~clk;
    fetch_unit #(.RESET_PC(32'h0000_0060)) dut (
        .clk(clk), .rst(rst), .imem_address(imem_address), .imem_read(imem_read),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp), .instruction(instruction),
        .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a * 32'h9E37_79B1 ^ 32'hC0DE_0000;
    endfunction
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic restart(input logic [31:0] pc);
        logic [31:0] p = {pc[31:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 2048; i++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic hold_reset(input bit men);
        tick();
        rst = 0;
        mem_en = men;
        imem_resp = 0;
        redirect = 0;
        max_lat = 0;
        tick();
        tick();
    endtask
    task automatic release_reset();
        rd_log.delete();
        restart(32'h60);
        rst = 1;
    endtask
    task automatic wait_read(input string nm);
        int n = 0;
        @(negedge clk);
        while (!imem_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_read"}, 32'(imem_read), 32'd1);
    endtask
    task automatic serve(input logic [31:0] a, input string nm);
        wait_read(nm);
        check({nm, "_addr"}, imem_address, a);
        @(posedge clk);
        #2;
        imem_resp = 1;
        imem_rdata = mem_fn(imem_address);
        tick();
        imem_resp = 0;
    endtask
    // memory model: random-latency responder, active only when mem_en is set
    initial forever begin
        @(posedge clk);
        #1;
        if (mem_en) begin
            imem_resp = 0;
            if (!rst) lat = 0;
            else if (imem_read) begin
                if (lat == 0) begin
                    imem_resp = 1;
                    imem_rdata = mem_fn(imem_address);
                    rd_log.push_back(imem_address);
                    lat = $urandom_range(0, max_lat);
                end else lat--;
            end
        end
    end
    // monitor: scoreboard pop on every accepted instruction, plus request-hold protocol
    initial begin
        logic p_rst = 0, p_read = 0, p_resp = 0;
        logic [31:0] p_addr = 0, e;
        forever begin
            @(negedge clk);
            if (rst && instr_valid && instr_ready) begin
                accepts++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_underflow: got pc %h with nothing expected", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e);
                    check("instruction", instruction, mem_fn(e));
                end
            end
            if (rst && p_rst && p_read && !p_resp) begin
                check("addr_hold", imem_address, p_addr);
                check("read_hold", 32'(imem_read), 32'd1);
            end
            p_rst = rst;
            p_read = imem_read;
            p_resp = imem_resp;
            p_addr = imem_address;
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        #1 rst = 0;
        #2;
        check("rst_read", 32'(imem_read), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_addr", imem_address, 32'h60);
        check("rst_instr", instruction, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        // in-order streaming with single-cycle memory
        hold_reset(1);
        instr_ready = 1;
        release_reset();
        @(negedge clk);
        check("first_idle", 32'(imem_read), 32'd0);
        tick();
        @(negedge clk);
        check("first_read", 32'(imem_read), 32'd1);
        check("first_addr", imem_address, 32'h60);
        repeat (10) tick();
        check("log0", rd_log[0], 32'h60);
        check("log1", rd_log[1], 32'h64);
        check("log2", rd_log[2], 32'h68);
        // decode stalled: buffer fills then fetching stops
        hold_reset(1);
        instr_ready = 0;
        release_reset();
        repeat (12) tick();
        @(negedge clk);
        check("stall_reads", rd_log.size(), DEPTH);
        check("stall_read", 32'(imem_read), 32'd0);
        check("stall_valid", 32'(instr_valid), 32'd1);
        check("stall_pc", instr_pc, 32'h60);
        check("stall_instr", instruction, mem_fn(32'h60));
        @(posedge clk);
        #3 rst = 0;
        #1;
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_addr", imem_address, 32'h60);
        // late response around reset is ignored; async reset drops a pending read
        hold_reset(0);
        imem_resp = 1;
        imem_rdata = 32'hDEAD_BEEF;
        release_reset();
        tick();
        imem_resp = 0;
        tick();
        @(negedge clk);
        check("pend_read", 32'(imem_read), 32'd1);
        check("pend_addr", imem_address, 32'h60);
        @(posedge clk);
        #3 rst = 0;
        #1;
        check("async_read", 32'(imem_read), 32'd0);
        // redirect while a request is outstanding
        hold_reset(0);
        instr_ready = 1;
        release_reset();
        serve(32'h60, "d60");
        @(negedge clk);
        check("d_addr64", imem_address, 32'h64);
        tick();
        redirect = 1;
        redirect_pc = 32'h0000_0103;
        restart(32'h100);
        @(negedge clk);
        check("drain_addr_a", imem_address, 32'h64);
        tick();
        redirect = 0;
        tick();
        @(negedge clk);
        check("drain_addr_b", imem_address, 32'h64);
        check("drain_read", 32'(imem_read), 32'd1);
        tick();
        imem_resp = 1;
        imem_rdata = mem_fn(32'h64);
        tick();
        imem_resp = 0;
        @(negedge clk);
        check("redir_addr", imem_address, 32'h100);
        serve(32'h100, "d100");
        // redirect coinciding with the response for 0x68
        hold_reset(0);
        instr_ready = 1;
        release_reset();
        serve(32'h60, "e60");
        serve(32'h64, "e64");
        wait_read("e68");
        check("e68_addr", imem_address, 32'h68);
        @(posedge clk);
        #2;
        imem_resp = 1;
        imem_rdata = mem_fn(32'h68);
        redirect = 1;
        redirect_pc = 32'h200;
        restart(32'h200);
        tick();
        imem_resp = 0;
        redirect = 0;
        @(negedge clk);
        check("coin_addr", imem_address, 32'h200);
        // wrap of the fetch address through a DRAIN
        tick();
        redirect = 1;
        redirect_pc = 32'hFFFF_FFFF;
        restart(32'hFFFF_FFFC);
        tick();
        redirect = 0;
        serve(32'h200, "f200");
        serve(32'hFFFF_FFFC, "fwrap");
        @(negedge clk);
        check("wrap_addr", imem_address, 32'h0);
        serve(32'h0, "f0");
        tick();
        // fill the buffer, then redirect from IDLE
        instr_ready = 0;
        for (int i = 0; i < DEPTH; i++) serve(32'h4 + 32'(4 * i), "gfill");
        @(negedge clk);
        check("full_read", 32'(imem_read), 32'd0);
        check("full_pc", instr_pc, 32'h4);
        tick();
        redirect = 1;
        redirect_pc = 32'h300;
        restart(32'h300);
        @(negedge clk);
        check("redir_valid", 32'(instr_valid), 32'd0);
        tick();
        redirect = 0;
        instr_ready = 1;
        @(negedge clk);
        check("idle_redir_addr", imem_address, 32'h300);
        check("idle_redir_read", 32'(imem_read), 32'd1);
        check("flushed", 32'(instr_valid), 32'd0);
        serve(32'h300, "g300");
        tick();
        // randomized traffic against the scoreboard
        hold_reset(1);
        release_reset();
        a0 = accepts;
        for (int c = 0; c < 2000; c++) begin
            tick();
            instr_ready = $urandom_range(0, 3) != 0;
            max_lat = $urandom_range(0, 3);
            if ($urandom_range(0, 24) == 0) begin
                redirect = 1;
                redirect_pc = $urandom;
                restart(redirect_pc);
            end else redirect = 0;
        end
        tick();
        redirect = 0;
        check("progress", 32'(accepts - a0 > 100), 32'd1);
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
